// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - shared opcode and FSM state types for seq_alu
// Contents:
//   op_t    : 3-bit opcode (OP_ADD .. OP_MUL)
//   state_t : controller state (ST_IDLE, ST_MUL)
package seq_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/seq_alu_mul.sv
// rtl/seq_alu_mul.sv - iterative shift-add unsigned multiplier for seq_alu
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture a/b and perform the first iteration
//   a, b       : multiplicand / multiplier (WIDTH bits)
//   prod       : running product, final WIDTH iterations after load
//   last       : iteration counter has reached zero (product complete)
module seq_alu_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] prod,
    output logic               last
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    // acc = {partial_hi, remaining multiplier bits}. Each step adds the
    // multiplicand into the high half when the current multiplier LSB is
    // set, then shifts the whole accumulator right by one.
    function automatic logic [2*WIDTH-1:0] mul_step(
        input logic [2*WIDTH-1:0] cur,
        input logic [WIDTH-1:0]   m
    );
        logic [WIDTH:0] sum;
        sum = {1'b0, cur[2*WIDTH-1:WIDTH]} + (cur[0] ? {1'b0, m} : '0);
        return {sum, cur[WIDTH-1:1]};
    endfunction

    // The first iteration happens on the load edge so that WIDTH steps are
    // complete when the counter reaches zero, WIDTH-1 edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (load) begin
            mcand <= a;
            acc   <= mul_step({{WIDTH{1'b0}}, b}, a);
            cnt   <= CW'(WIDTH - 1);
        end else if (cnt != '0) begin
            acc <= mul_step(acc, mcand);
            cnt <= cnt - 1'b1;
        end
    end

    assign prod = acc;
    assign last = (cnt == '0);

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - clocked ALU with start/ready handshake and iterative MUL
// Optional feature macro: SEQ_ALU_MUL_EN (enables the shift-add multiplier).
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   start, op, a, b      : request, accepted on an edge where ready=1
//   ready                : idle and able to accept
//   done                 : one-cycle pulse when result/flags update
//   result, result_hi    : low word, MUL high word (0 for other ops)
//   flag_z/c/v/n         : zero, carry/borrow, signed overflow, negative
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_n
);

    localparam int SW = $clog2(WIDTH);

    state_t state;

    assign ready = (state == ST_IDLE);

    // Single-cycle datapath
    logic [WIDTH-1:0] s_res;
    logic             s_c;
    logic             s_v;
    logic [WIDTH:0]   ext;

    always_comb begin
        s_res = '0;
        s_c   = 1'b0;
        s_v   = 1'b0;
        ext   = '0;
        case (op)
            OP_ADD: begin
                ext   = {1'b0, a} + {1'b0, b};
                s_res = ext[WIDTH-1:0];
                s_c   = ext[WIDTH];
                s_v   = (a[WIDTH-1] == b[WIDTH-1]) && (s_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // The extra top bit of the extended difference is the borrow.
                ext   = {1'b0, a} - {1'b0, b};
                s_res = ext[WIDTH-1:0];
                s_c   = ext[WIDTH];
                s_v   = (a[WIDTH-1] != b[WIDTH-1]) && (s_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: s_res = a & b;
            OP_OR:  s_res = a | b;
            OP_XOR: s_res = a ^ b;
            OP_SHL: s_res = a << b[SW-1:0];
            OP_SHR: s_res = a >> b[SW-1:0];
            default: s_res = '0;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    logic [2*WIDTH-1:0] mul_prod;
    logic               mul_last;
    logic               mul_load;

    assign mul_load = start && ready && (op == OP_MUL);

    seq_alu_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (mul_load),
        .a     (a),
        .b     (b),
        .prod  (mul_prod),
        .last  (mul_last)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            done      <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            flag_n    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (op == OP_MUL) begin
`ifdef SEQ_ALU_MUL_EN
                            state <= ST_MUL;
`else
                            // Without a multiplier MUL retires at once as zero.
                            done      <= 1'b1;
                            result    <= '0;
                            result_hi <= '0;
                            flag_z    <= 1'b1;
                            flag_c    <= 1'b0;
                            flag_v    <= 1'b0;
                            flag_n    <= 1'b0;
`endif
                        end else begin
                            done      <= 1'b1;
                            result    <= s_res;
                            result_hi <= '0;
                            flag_z    <= (s_res == '0);
                            flag_c    <= s_c;
                            flag_v    <= s_v;
                            flag_n    <= s_res[WIDTH-1];
                        end
                    end
                end
                ST_MUL: begin
`ifdef SEQ_ALU_MUL_EN
                    if (mul_last) begin
                        state     <= ST_IDLE;
                        done      <= 1'b1;
                        result    <= mul_prod[WIDTH-1:0];
                        result_hi <= mul_prod[2*WIDTH-1:WIDTH];
                        flag_z    <= (mul_prod == '0);
                        flag_c    <= (mul_prod[2*WIDTH-1:WIDTH] != '0);
                        flag_v    <= 1'b0;
                        flag_n    <= mul_prod[2*WIDTH-1];
                    end
`else
                    state <= ST_IDLE;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking randomized testbench for seq_alu (WIDTH=8)
module tb_seq_alu;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = 3'd0;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic       ready;
    logic       done;
    logic [7:0] result;
    logic [7:0] result_hi;
    logic       flag_z, flag_c, flag_v, flag_n;

    int tests = 0;
    int fails = 0;

    seq_alu #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .ready     (ready),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flag_n    (flag_n)
    );

    always #5 clk = ~clk;

    wire [19:0] got = {result_hi, result, flag_z, flag_c, flag_v, flag_n};

    // Reference: {result_hi, result, z, c, v, n} from integer arithmetic.
    function automatic logic [19:0] model(input int o, input int x, input int y);
        int r, rh, s, sx, sy, p;
        bit z, c, v, n;
        r = 0; rh = 0; c = 0; v = 0; z = 0; n = 0;
        sx = (x >= 128) ? x - 256 : x;
        sy = (y >= 128) ? y - 256 : y;
        case (o)
            0: begin s = x + y; r = s % 256; c = (s > 255); s = sx + sy; v = (s > 127) || (s < -128); end
            1: begin r = (x - y + 256) % 256; c = (x < y); s = sx - sy; v = (s > 127) || (s < -128); end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: r = (x << (y % 8)) % 256;
            6: r = x >> (y % 8);
            default: begin
`ifdef SEQ_ALU_MUL_EN
                p = x * y; r = p % 256; rh = p / 256;
`else
                p = 0;
`endif
            end
        endcase
        if (o == 7) begin
            z = (r == 0) && (rh == 0);
            c = (rh != 0);
            n = (rh >= 128);
        end else begin
            z = (r == 0);
            n = (r >= 128);
        end
        return {8'(rh), 8'(r), z, c, v, n};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (got !== 20'h0 || done !== 1'b0 || ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: got out=%h done=%b ready=%b, want out=0 done=0 ready=1", got, done, ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL after_reset: got ready=%b done=%b, want ready=1 done=0", ready, done);
        end
    endtask

    task automatic test_add_basic();
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 8'd3; b = 8'd2;
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b1 || got !== {8'h00, 8'h05, 4'b0000}) begin
            fails++;
            $display("FAIL add_basic: got done=%b out=%h, want done=1 out=%h", done, got, {8'h00, 8'h05, 4'b0000});
        end
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0 || result !== 8'h05) begin
            fails++;
            $display("FAIL add_hold: got done=%b result=%h, want done=0 result=05", done, result);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] exp_r [7] = '{8'h81, 8'h7F, 8'h00, 8'h81, 8'h81, 8'h00, 8'h40};
        logic [3:0] exp_f [7] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0001, 4'b1000, 4'b0000};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            start = 1'b1; op = 3'(i); a = 8'h80; b = 8'h01;
            @(posedge clk); #1;
            tests++;
            if (done !== 1'b1 || got !== {8'h00, exp_r[i], exp_f[i]}) begin
                fails++;
                $display("FAIL sweep_op%0d: got done=%b out=%h, want done=1 out=%h", i, done, got, {8'h00, exp_r[i], exp_f[i]});
            end
        end
        @(negedge clk); start = 1'b0;
    endtask

    task automatic test_edges();
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 8'hFF; b = 8'h01;
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b1 || got !== {8'h00, 8'h00, 4'b1100}) begin
            fails++;
            $display("FAIL add_carry: got done=%b out=%h, want done=1 out=%h", done, got, {8'h00, 8'h00, 4'b1100});
        end
        @(negedge clk);
        op = 3'd1; a = 8'h01; b = 8'h02;
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b1 || got !== {8'h00, 8'hFF, 4'b0101}) begin
            fails++;
            $display("FAIL sub_borrow: got done=%b out=%h, want done=1 out=%h", done, got, {8'h00, 8'hFF, 4'b0101});
        end
        @(negedge clk); start = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            start = 1'b1;
`ifdef SEQ_ALU_MUL_EN
            op = 3'($urandom_range(0, 6));
`else
            op = 3'($urandom_range(0, 7));
`endif
            a = 8'($urandom); b = 8'($urandom);
            if (i % 10 == 0) b = 8'($urandom_range(0, 1));
            exp = model(int'(op), int'(a), int'(b));
            @(posedge clk); #1;
            tests++;
            if (done !== 1'b1 || ready !== 1'b1 || got !== exp) begin
                fails++;
                $display("FAIL random_op%0d a=%h b=%h: got done=%b ready=%b out=%h, want done=1 ready=1 out=%h",
                         op, a, b, done, ready, got, exp);
            end
        end
        @(negedge clk); start = 1'b0;
    endtask

`ifdef SEQ_ALU_MUL_EN
    task automatic test_mul();
        logic [7:0]  xs [6];
        logic [7:0]  ys [6];
        logic [19:0] exp;
        xs[0] = 8'd15; ys[0] = 8'd17;
        xs[1] = 8'hFF; ys[1] = 8'hFF;
        xs[2] = 8'h00; ys[2] = 8'h9C;
        for (int k = 3; k < 6; k++) begin
            xs[k] = 8'($urandom); ys[k] = 8'($urandom);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            start = 1'b1; op = 3'd7; a = xs[k]; b = ys[k];
            exp = model(7, int'(xs[k]), int'(ys[k]));
            @(posedge clk); #1;
            tests++;
            if (ready !== 1'b0 || done !== 1'b0) begin
                fails++;
                $display("FAIL mul_accept%0d: got ready=%b done=%b, want ready=0 done=0", k, ready, done);
            end
            // Requests while busy must be ignored.
            for (int c = 1; c < 8; c++) begin
                @(negedge clk);
                start = 1'($urandom_range(0, 1)); op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
                @(posedge clk); #1;
                tests++;
                if (ready !== 1'b0 || done !== 1'b0) begin
                    fails++;
                    $display("FAIL mul_busy%0d_c%0d: got ready=%b done=%b, want ready=0 done=0", k, c, ready, done);
                end
            end
            @(negedge clk); start = 1'b0;
            @(posedge clk); #1;
            tests++;
            if (done !== 1'b1 || ready !== 1'b1 || got !== exp) begin
                fails++;
                $display("FAIL mul_result%0d %h*%h: got done=%b ready=%b out=%h, want done=1 ready=1 out=%h",
                         k, xs[k], ys[k], done, ready, got, exp);
            end
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL mul_done_pulse: got done=%b, want 0", done);
        end
    endtask

    task automatic test_mul_reset();
        @(negedge clk);
        start = 1'b1; op = 3'd7; a = 8'hC3; b = 8'h5A;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (got !== 20'h0 || done !== 1'b0 || ready !== 1'b1) begin
            fails++;
            $display("FAIL mul_reset_state: got out=%h done=%b ready=%b, want out=0 done=0 ready=1", got, done, ready);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            tests++;
            if (done !== 1'b0 || ready !== 1'b1 || got !== 20'h0) begin
                fails++;
                $display("FAIL mul_abort_c%0d: got done=%b ready=%b out=%h, want done=0 ready=1 out=0", c, done, ready, got);
            end
        end
    endtask
`else
    task automatic test_mul_disabled();
        @(negedge clk);
        start = 1'b1; op = 3'd7; a = 8'd3; b = 8'd4;
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b1 || ready !== 1'b1 || got !== {8'h00, 8'h00, 4'b1000}) begin
            fails++;
            $display("FAIL mul_off: got done=%b ready=%b out=%h, want done=1 ready=1 out=%h",
                     done, ready, got, {8'h00, 8'h00, 4'b1000});
        end
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            tests++;
            if (ready !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL mul_off_idle_c%0d: got ready=%b done=%b, want ready=1 done=0", c, ready, done);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add_basic();
        test_sweep();
        test_edges();
        test_back_to_back();
`ifdef SEQ_ALU_MUL_EN
        test_mul();
        test_mul_reset();
`else
        test_mul_disabled();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
